// File: rtl/conv_frame_ctrl.sv
// Frame sequencer feeding the conv engine: gates the pixel stream under valid/ready,
// tracks raster position, flags complete KxK windows and frames one image per start.
module conv_frame_ctrl #(
  parameter  int unsigned IMG_W  = 32,
  parameter  int unsigned IMG_H  = 32,
  parameter  int unsigned KERNEL = 5,
  parameter  int unsigned PIX_W  = 8,
  localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix,
  output logic             o_pix_ready,
  input  logic             i_conv_full,
  input  logic             i_out_ready,
  output logic             o_conv_valid,
  output logic [PIX_W-1:0] o_conv_pix,
  output logic             o_win_valid,
  output logic [RW-1:0]    o_out_row,
  output logic [CW-1:0]    o_out_col,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned KM1 = KERNEL - 1;
  localparam int unsigned KM2 = (KERNEL >= 2) ? KERNEL - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  // A 1x1 kernel has no priming rows, so the frame starts directly in RUN.
  localparam state_t FIRST_ST = (KERNEL == 1) ? S_RUN : S_FILL;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_hit;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign win_hit  = (row >= RW'(KM1)) && (col >= CW'(KM1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start && !i_abort) state_d = FIRST_ST;
      S_FILL: begin
        if (i_abort)                                           state_d = S_IDLE;
        else if (accept && col_last && (row == RW'(KM2)))      state_d = S_RUN;
      end
      S_RUN: begin
        if (i_abort)                                           state_d = S_IDLE;
        else if (accept && col_last && row_last)               state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status decode; ready drops in the same cycle as any stall.
  always_comb begin
    o_pix_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_FILL, S_RUN: begin
        o_pix_ready = !i_conv_full && i_out_ready;
        o_busy      = 1'b1;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
    accept = i_pix_valid && o_pix_ready;
  end

  // Raster position; abort and idle both hold the counters at the frame origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if ((state_q == S_IDLE) || i_abort) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Registered conv-side outputs, one cycle behind the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_conv_valid <= 1'b0;
      o_conv_pix   <= '0;
      o_win_valid  <= 1'b0;
      o_out_row    <= '0;
      o_out_col    <= '0;
    end else begin
      o_conv_valid <= accept;
      o_win_valid  <= accept && win_hit;
      if (accept) o_conv_pix <= i_pix;
      if (accept && win_hit) begin
        o_out_row <= row - RW'(KM1);
        o_out_col <= col - CW'(KM1);
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: 8x6 K=3 main instance plus K=1 and 3x3 corner instances.
`timescale 1ns/1ps
module tb_conv_frame_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 6;
  localparam int unsigned K    = 3;
  localparam int unsigned PW   = 8;
  localparam int unsigned NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, abort, pix_valid, conv_full, out_ready;
  logic [PW-1:0] pix;
  logic          pix_ready, conv_valid, win_valid, busy, done;
  logic [PW-1:0] conv_pix;
  logic [2:0]    out_row, out_col;

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .KERNEL(K), .PIX_W(PW)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_pix_valid(pix_valid), .i_pix(pix), .o_pix_ready(pix_ready),
    .i_conv_full(conv_full), .i_out_ready(out_ready),
    .o_conv_valid(conv_valid), .o_conv_pix(conv_pix), .o_win_valid(win_valid),
    .o_out_row(out_row), .o_out_col(out_col), .o_busy(busy), .o_done(done)
  );

  // Corner-case instances share one simple stimulus set.
  logic          d_start, d_valid;
  logic [PW-1:0] d_pix;
  logic          k1_ready, k1_cv, k1_wv, k1_busy, k1_done;
  logic [PW-1:0] k1_pix;
  logic [0:0]    k1_row;
  logic [1:0]    k1_col;
  logic          k3_ready, k3_cv, k3_wv, k3_busy, k3_done;
  logic [PW-1:0] k3_pix;
  logic [1:0]    k3_row, k3_col;

  conv_frame_ctrl #(.IMG_W(4), .IMG_H(2), .KERNEL(1), .PIX_W(PW)) u_k1 (
    .clk(clk), .rst_n(rst_n), .i_start(d_start), .i_abort(1'b0),
    .i_pix_valid(d_valid), .i_pix(d_pix), .o_pix_ready(k1_ready),
    .i_conv_full(1'b0), .i_out_ready(1'b1),
    .o_conv_valid(k1_cv), .o_conv_pix(k1_pix), .o_win_valid(k1_wv),
    .o_out_row(k1_row), .o_out_col(k1_col), .o_busy(k1_busy), .o_done(k1_done)
  );

  conv_frame_ctrl #(.IMG_W(3), .IMG_H(3), .KERNEL(3), .PIX_W(PW)) u_k3 (
    .clk(clk), .rst_n(rst_n), .i_start(d_start), .i_abort(1'b0),
    .i_pix_valid(d_valid), .i_pix(d_pix), .o_pix_ready(k3_ready),
    .i_conv_full(1'b0), .i_out_ready(1'b1),
    .o_conv_valid(k3_cv), .o_conv_pix(k3_pix), .o_win_valid(k3_wv),
    .o_out_row(k3_row), .o_out_col(k3_col), .o_busy(k3_busy), .o_done(k3_done)
  );

  typedef struct {
    logic [PW-1:0] pix;
    logic          win;
    int            row;
    int            col;
    logic          last;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0, n_pass = 0;
  int m_state = 0;   // 0 idle, 1 active, 2 done
  int m_idx = 0;
  int cyc = 0;
  int n_acc, n_out, n_win, n_done, first_win, last_row, last_col, done_cyc, start_cyc;
  bit need_new = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_stats();
    n_acc = 0; n_out = 0; n_win = 0; n_done = 0; first_win = -1;
    last_row = -1; last_col = -1; done_cyc = -1; start_cyc = -1;
  endtask

  task automatic monitor();
    exp_t e;
    logic was_last;
    was_last = 1'b0;
    check("busy", int'(busy), int'(m_state != 0));
    if (conv_valid) begin
      if (sb_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("conv_pix", int'(conv_pix), int'(e.pix));
        check("win_valid", int'(win_valid), int'(e.win));
        if (e.win) begin
          check("out_row", int'(out_row), e.row);
          check("out_col", int'(out_col), e.col);
          if (n_win == 0) first_win = n_out;
          n_win++;
          last_row = int'(out_row);
          last_col = int'(out_col);
        end
        n_out++;
        was_last = e.last;
      end
    end else begin
      check("win_without_conv", int'(win_valid), 0);
    end
    check("done", int'(done), int'(was_last));
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  // One clock: check last edge's outputs, drive inputs, predict acceptance and next state.
  task automatic cycle(input logic st, input logic ab, input logic v, input logic f, input logic r);
    exp_t e;
    logic acc;
    @(negedge clk);
    cyc++;
    monitor();
    if (need_new) begin
      pix = PW'($urandom);
      need_new = 1'b0;
    end
    start = st; abort = ab; pix_valid = v; conv_full = f; out_ready = r;
    #1;
    check("pix_ready", int'(pix_ready), int'((m_state == 1) && !f && r));
    acc = v && pix_ready;
    if (acc) begin
      e.pix  = pix;
      e.win  = ((m_idx / W) >= K - 1) && ((m_idx % W) >= K - 1);
      e.row  = int'(m_idx / W) - int'(K - 1);
      e.col  = int'(m_idx % W) - int'(K - 1);
      m_idx++;
      e.last = (m_idx == NPIX);
      sb_q.push_back(e);
      n_acc++;
      need_new = 1'b1;
    end
    if (m_state == 0) begin
      if (st && !ab) begin
        m_state = 1;
        m_idx = 0;
        start_cyc = cyc;
      end
    end else if (ab) m_state = 0;
    else if (m_state == 2) m_state = 0;
    else if (acc && (m_idx == NPIX)) m_state = 2;
  endtask

  task automatic run_frame(input bit stall, input int abort_at, input bit poke_start);
    int budget;
    logic v, f, r, st, ab;
    budget = 3000;
    clear_stats();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    while ((m_state != 0) && (budget > 0)) begin
      budget--;
      f  = stall ? ($urandom_range(0, 9) < 3) : 1'b0;
      r  = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      v  = stall ? ($urandom_range(0, 9) < 8) : 1'b1;
      ab = (abort_at > 0) && (n_acc == abort_at);
      st = poke_start && ((n_acc == 10) || (m_state == 2));
      cycle(st, ab, v, f, r);
    end
    if (budget == 0) check("frame_timeout", 0, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_full_frame(input string tag);
    check({tag, "_accepts"}, n_acc, 48);
    check({tag, "_outs"}, n_out, 48);
    check({tag, "_windows"}, n_win, 24);
    check({tag, "_first_win"}, first_win, 18);
    check({tag, "_last_row"}, last_row, 3);
    check({tag, "_last_col"}, last_col, 5);
    check({tag, "_done_cnt"}, n_done, 1);
  endtask

  task automatic run_corner();
    int k1_n, k1_nd, k3_n, k3_w, k3_nd;
    k1_n = 0; k1_nd = 0; k3_n = 0; k3_w = 0; k3_nd = 0;
    @(negedge clk);
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    d_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (k1_cv) begin
        check("k1_win", int'(k1_wv), 1);
        check("k1_row", int'(k1_row), k1_n / 4);
        check("k1_col", int'(k1_col), k1_n % 4);
        k1_n++;
      end
      if (k1_done) k1_nd++;
      if (k3_cv) begin
        k3_n++;
        if (k3_wv) begin
          check("k3_win_index", k3_n, 9);
          check("k3_row", int'(k3_row), 0);
          check("k3_col", int'(k3_col), 0);
          k3_w++;
        end
      end
      if (k3_done) k3_nd++;
      d_pix = d_pix + PW'(1);
    end
    d_valid = 1'b0;
    check("k1_outputs", k1_n, 8);
    check("k1_done_cnt", k1_nd, 1);
    check("k3_outputs", k3_n, 9);
    check("k3_windows", k3_w, 1);
    check("k3_done_cnt", k3_nd, 1);
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; pix_valid = 1'b0; conv_full = 1'b0; out_ready = 1'b1;
    pix = 8'h5a;
    d_start = 1'b0; d_valid = 1'b0; d_pix = 8'h01;
    clear_stats();

    #12;
    check("rst_ready", int'(pix_ready), 0);
    check("rst_conv_valid", int'(conv_valid), 0);
    check("rst_win_valid", int'(win_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_conv_pix", int'(conv_pix), 0);
    check("rst_out_row", int'(out_row), 0);
    check("rst_out_col", int'(out_col), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(1'b0, 0, 1'b0);
    check_full_frame("basic");
    check("basic_done_latency", done_cyc - start_cyc, 49);

    run_frame(1'b1, 0, 1'b0);
    check_full_frame("stall");

    run_frame(1'b0, 20, 1'b0);
    check("abort_no_done", n_done, 0);
    check("abort_inflight_once", n_out, n_acc);
    check("abort_busy", int'(busy), 0);
    run_frame(1'b0, 0, 1'b0);
    check_full_frame("post_abort");

    run_frame(1'b0, 0, 1'b1);
    check_full_frame("ignored_start");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("start_abort_idle", int'(busy), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    clear_stats();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", int'(pix_ready), 0);
    check("arst_conv_valid", int'(conv_valid), 0);
    check("arst_win_valid", int'(win_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_conv_pix", int'(conv_pix), 0);
    check("arst_out_row", int'(out_row), 0);
    check("arst_out_col", int'(out_col), 0);
    #1 rst_n = 1'b1;
    sb_q.delete();
    m_state = 0;
    pix_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("arst_no_done", n_done, 0);
    run_frame(1'b0, 0, 1'b0);
    check_full_frame("post_reset");

    run_corner();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
